biquad_sequencer: RTL and testbench



---
 rtl/biquad_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_biquad_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_sequencer.sv
// biquad_sequencer
//   Front end for the biquad filter stage. Buffers one audio sample and one
//   coefficient set, hands them to the filter through level-held
//   request/acknowledge handshakes (one request at a time), and returns the
//   filtered sample downstream with a one-cycle strobe. It also provides an
//   unfiltered bypass, counts dropped input samples, and aborts requests the
//   filter never acknowledges.
//
// Handshakes:
//   Upstream strobes (sample_valid, coef_valid) are single-cycle with no
//   back-pressure. A sample that arrives while another is still pending
//   replaces it and counts as an overrun. A newer coefficient set replaces
//   the older one without being counted.
//   Filter requests (new_sample, new_coefficients) are levels. Each is held
//   until its acknowledge (computation_done, coefficients_updated) is seen
//   high or the timeout expires. Both requests are then low for exactly one
//   RELEASE cycle. The two requests are never high together. filt_sample and
//   *_load only change in IDLE, so they are stable for the whole request.
//   Acknowledges seen in IDLE or RELEASE are ignored. sample_out_valid is a
//   single-cycle strobe that qualifies sample_out.
//
// Ports:
//   CLOCK_50, Reset          clock; synchronous active-high reset
//   sample_valid, sample_in  codec sample strobe and data
//   coef_valid, *_in         coefficient-set strobe and signed 4.14 values
//   bypass                   1 = samples skip the filter (sampled in IDLE)
//   new_sample, filt_sample  sample request and sample to the filter
//   new_coefficients, *_load coefficient request and values to the filter
//   computation_done         filter acknowledge; filt_result valid with it
//   coefficients_updated     filter acknowledge for coefficients
//   sample_out(_valid)       output sample and its strobe
//   overrun_cnt, timeout_cnt saturating event counters
//   state_dbg                current FSM state for observation
module biquad_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               sample_valid,
  input  logic [15:0]        sample_in,
  input  logic               coef_valid,
  input  logic [17:0]        a0_in,
  input  logic [17:0]        a1_in,
  input  logic [17:0]        a2_in,
  input  logic [17:0]        b1_in,
  input  logic [17:0]        b2_in,
  input  logic               bypass,
  output logic               new_sample,
  output logic               new_coefficients,
  output logic [15:0]        filt_sample,
  output logic [17:0]        a0_load,
  output logic [17:0]        a1_load,
  output logic [17:0]        a2_load,
  output logic [17:0]        b1_load,
  output logic [17:0]        b2_load,
  input  logic               computation_done,
  input  logic               coefficients_updated,
  input  logic [15:0]        filt_result,
  output logic [15:0]        sample_out,
  output logic               sample_out_valid,
  output logic [CNT_W-1:0]   overrun_cnt,
  output logic [CNT_W-1:0]   timeout_cnt,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COEF_REQ = 2'd1,
    SAMP_REQ = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [17:0]      A0_UNITY = 18'h04000;  // 1.0 in 4.14

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [15:0]        sample_pend_q, sample_pend_d;
  logic               samp_pend_f_q, samp_pend_f_d;
  logic               coef_pend_f_q, coef_pend_f_d;
  logic [17:0]        a0_sh_q, a0_sh_d, a1_sh_q, a1_sh_d, a2_sh_q, a2_sh_d;
  logic [17:0]        b1_sh_q, b1_sh_d, b2_sh_q, b2_sh_d;
  logic [17:0]        a0_load_q, a0_load_d, a1_load_q, a1_load_d;
  logic [17:0]        a2_load_q, a2_load_d, b1_load_q, b1_load_d;
  logic [17:0]        b2_load_q, b2_load_d;
  logic [15:0]        filt_sample_q, filt_sample_d;
  logic [15:0]        sample_out_q, sample_out_d;
  logic               sample_out_valid_q, sample_out_valid_d;
  logic [CNT_W-1:0]   overrun_cnt_q, overrun_cnt_d;
  logic [CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;

  logic               samp_take;   // IDLE consumes the pending sample
  logic               coef_take;   // IDLE consumes the pending coefficient set
  logic               abort;       // request timed out this cycle

  // Next-state and datapath
  always_comb begin
    state_d            = state_q;
    tmr_d              = tmr_q;
    a0_load_d          = a0_load_q;
    a1_load_d          = a1_load_q;
    a2_load_d          = a2_load_q;
    b1_load_d          = b1_load_q;
    b2_load_d          = b2_load_q;
    filt_sample_d      = filt_sample_q;
    sample_out_d       = sample_out_q;
    sample_out_valid_d = 1'b0;
    samp_take          = 1'b0;
    coef_take          = 1'b0;
    abort              = 1'b0;

    case (state_q)
      IDLE: begin
        // Coefficients first so the next sample uses the newest set.
        if (coef_pend_f_q) begin
          coef_take = 1'b1;
          a0_load_d = a0_sh_q;
          a1_load_d = a1_sh_q;
          a2_load_d = a2_sh_q;
          b1_load_d = b1_sh_q;
          b2_load_d = b2_sh_q;
          tmr_d     = '0;
          state_d   = COEF_REQ;
        end else if (samp_pend_f_q) begin
          samp_take = 1'b1;
          if (bypass) begin
            sample_out_d       = sample_pend_q;
            sample_out_valid_d = 1'b1;
          end else begin
            filt_sample_d = sample_pend_q;
            tmr_d         = '0;
            state_d       = SAMP_REQ;
          end
        end
      end
      COEF_REQ: begin
        if (coefficients_updated) begin
          state_d = RELEASE;
        end else if (tmr_q == TMR_LAST) begin
          abort   = 1'b1;
          state_d = RELEASE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SAMP_REQ: begin
        if (computation_done) begin
          sample_out_d       = filt_result;
          sample_out_valid_d = 1'b1;
          state_d            = RELEASE;
        end else if (tmr_q == TMR_LAST) begin
          // Filter never answered: pass the sample through rather than lose it.
          abort              = 1'b1;
          sample_out_d       = filt_sample_q;
          sample_out_valid_d = 1'b1;
          state_d            = RELEASE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input capture, independent of the FSM
  always_comb begin
    sample_pend_d = sample_pend_q;
    samp_pend_f_d = samp_pend_f_q;
    overrun_cnt_d = overrun_cnt_q;
    coef_pend_f_d = coef_pend_f_q;
    a0_sh_d       = a0_sh_q;
    a1_sh_d       = a1_sh_q;
    a2_sh_d       = a2_sh_q;
    b1_sh_d       = b1_sh_q;
    b2_sh_d       = b2_sh_q;
    timeout_cnt_d = timeout_cnt_q;

    if (sample_valid) begin
      sample_pend_d = sample_in;
      samp_pend_f_d = 1'b1;
      if (samp_pend_f_q && !samp_take && (overrun_cnt_q != CNT_MAX)) begin
        overrun_cnt_d = overrun_cnt_q + 1'b1;
      end
    end else if (samp_take) begin
      samp_pend_f_d = 1'b0;
    end

    if (coef_valid) begin
      a0_sh_d       = a0_in;
      a1_sh_d       = a1_in;
      a2_sh_d       = a2_in;
      b1_sh_d       = b1_in;
      b2_sh_d       = b2_in;
      coef_pend_f_d = 1'b1;
    end else if (coef_take) begin
      coef_pend_f_d = 1'b0;
    end

    if (abort && (timeout_cnt_q != CNT_MAX)) begin
      timeout_cnt_d = timeout_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q            <= IDLE;
      tmr_q              <= '0;
      sample_pend_q      <= '0;
      samp_pend_f_q      <= 1'b0;
      coef_pend_f_q      <= 1'b0;
      a0_sh_q            <= '0;
      a1_sh_q            <= '0;
      a2_sh_q            <= '0;
      b1_sh_q            <= '0;
      b2_sh_q            <= '0;
      a0_load_q          <= A0_UNITY;
      a1_load_q          <= '0;
      a2_load_q          <= '0;
      b1_load_q          <= '0;
      b2_load_q          <= '0;
      filt_sample_q      <= '0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
      overrun_cnt_q      <= '0;
      timeout_cnt_q      <= '0;
    end else begin
      state_q            <= state_d;
      tmr_q              <= tmr_d;
      sample_pend_q      <= sample_pend_d;
      samp_pend_f_q      <= samp_pend_f_d;
      coef_pend_f_q      <= coef_pend_f_d;
      a0_sh_q            <= a0_sh_d;
      a1_sh_q            <= a1_sh_d;
      a2_sh_q            <= a2_sh_d;
      b1_sh_q            <= b1_sh_d;
      b2_sh_q            <= b2_sh_d;
      a0_load_q          <= a0_load_d;
      a1_load_q          <= a1_load_d;
      a2_load_q          <= a2_load_d;
      b1_load_q          <= b1_load_d;
      b2_load_q          <= b2_load_d;
      filt_sample_q      <= filt_sample_d;
      sample_out_q       <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
      overrun_cnt_q      <= overrun_cnt_d;
      timeout_cnt_q      <= timeout_cnt_d;
    end
  end

  // Requests decode straight from the state, so they can never overlap.
  assign new_sample       = (state_q == SAMP_REQ);
  assign new_coefficients = (state_q == COEF_REQ);
  assign filt_sample      = filt_sample_q;
  assign a0_load          = a0_load_q;
  assign a1_load          = a1_load_q;
  assign a2_load          = a2_load_q;
  assign b1_load          = b1_load_q;
  assign b2_load          = b2_load_q;
  assign sample_out       = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;
  assign overrun_cnt      = overrun_cnt_q;
  assign timeout_cnt      = timeout_cnt_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_biquad_sequencer.sv
// Testbench for biquad_sequencer: directed vectors, a behavioural filter that
// answers requests after a programmable latency, and a scoreboard monitor.
module tb_biquad_sequencer;

  // ---------------- clock / reset ----------------
  logic CLOCK_50 = 1'b0;
  logic Reset    = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        sample_valid, coef_valid, bypass;
  logic [15:0] sample_in;
  logic [17:0] a0_in, a1_in, a2_in, b1_in, b2_in;
  logic        new_sample, new_coefficients;
  logic [15:0] filt_sample;
  logic [17:0] a0_load, a1_load, a2_load, b1_load, b2_load;
  logic        computation_done, coefficients_updated;
  logic [15:0] filt_result;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic [7:0]  overrun_cnt, timeout_cnt;
  logic [1:0]  state_dbg;

  biquad_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .coef_valid(coef_valid),
    .a0_in(a0_in), .a1_in(a1_in), .a2_in(a2_in), .b1_in(b1_in), .b2_in(b2_in),
    .bypass(bypass),
    .new_sample(new_sample), .new_coefficients(new_coefficients),
    .filt_sample(filt_sample),
    .a0_load(a0_load), .a1_load(a1_load), .a2_load(a2_load),
    .b1_load(b1_load), .b2_load(b2_load),
    .computation_done(computation_done),
    .coefficients_updated(coefficients_updated),
    .filt_result(filt_result),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  int cyc = 0;
  int ns_rise_n = 0, ns_rise_cyc = 0, ns_run = 0, ns_len = 0;
  int nc_rise_cyc = 0, nc_fall_cyc = 0;
  int vcount = 0;
  logic [17:0] nc_a0_seen = '0;
  logic ns_prev = 1'b0, nc_prev = 1'b0;

  // ---------------- behavioural filter ----------------
  // filt_lat/coef_lat = 0 means the filter never acknowledges.
  int          filt_lat  = 2;
  int          coef_lat  = 1;
  logic [15:0] filt_mask = 16'h0000;

  initial begin
    int ncnt;
    int ccnt;
    ncnt = 0;
    ccnt = 0;
    computation_done     = 1'b0;
    coefficients_updated = 1'b0;
    filt_result          = 16'h0000;
    forever begin
      @(negedge CLOCK_50);
      if (new_sample) begin
        if (!computation_done) begin
          ncnt++;
          if (filt_lat > 0 && ncnt >= filt_lat) begin
            computation_done = 1'b1;
            filt_result      = filt_sample ^ filt_mask;
          end
        end
      end else begin
        ncnt             = 0;
        computation_done = 1'b0;
      end
      if (new_coefficients) begin
        if (!coefficients_updated) begin
          ccnt++;
          if (coef_lat > 0 && ccnt >= coef_lat) coefficients_updated = 1'b1;
        end
      end else begin
        ccnt                 = 0;
        coefficients_updated = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLOCK_50) begin
    logic [15:0] e;
    cyc++;
    if (!Reset) begin
      if (sample_out_valid) begin
        vcount++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: sample_out=%h with nothing expected", sample_out);
        end else begin
          e = exp_q.pop_front();
          if (sample_out !== e) begin
            errors++;
            $display("FAIL sample_out: got %h expected %h", sample_out, e);
          end
        end
      end
      if (new_sample || new_coefficients) begin
        checks++;
        if (new_sample && new_coefficients) begin
          errors++;
          $display("FAIL req_exclusive: new_sample=1 new_coefficients=1 expected one at most");
        end
      end
      if (new_sample && !ns_prev) begin
        ns_rise_n++;
        ns_rise_cyc = cyc;
        ns_run      = 0;
      end
      if (new_sample) ns_run++;
      if (!new_sample && ns_prev) ns_len = ns_run;
      if (new_coefficients && !nc_prev) begin
        nc_rise_cyc = cyc;
        nc_a0_seen  = a0_load;
      end
      if (!new_coefficients && nc_prev) nc_fall_cyc = cyc;
    end
    ns_prev = new_sample;
    nc_prev = new_coefficients;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_sample(input logic [15:0] s, input logic [15:0] e, input bit push);
    @(negedge CLOCK_50);
    sample_in    = s;
    sample_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge CLOCK_50);
    sample_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then let the FSM settle back to IDLE.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d outputs still outstanding after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic wait_new_sample(input string name, input int budget);
    int n;
    n = 0;
    while (!new_sample && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(name, 32'(new_sample), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, v0;
    sample_valid = 1'b0;
    coef_valid   = 1'b0;
    bypass       = 1'b0;
    sample_in    = '0;
    a0_in = '0; a1_in = '0; a2_in = '0; b1_in = '0; b2_in = '0;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("rst_new_sample", 32'(new_sample), 32'd0);
    check("rst_new_coef", 32'(new_coefficients), 32'd0);
    check("rst_a0_load", 32'(a0_load), 32'h04000);
    check("rst_b2_load", 32'(b2_load), 32'h0);
    check("rst_valid", 32'(sample_out_valid), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'h0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    check("rst_timeout", 32'(timeout_cnt), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    // Basic filtered sample: 1234 -> filter returns 0ABC after 2 cycles
    filt_lat  = 2;
    filt_mask = 16'h1234 ^ 16'h0ABC;
    send_sample(16'h1234, 16'h0ABC, 1'b1);
    drain("basic_drain", 50);
    check("basic_req_len", 32'(ns_len), 32'd2);
    check("basic_new_sample_low", 32'(new_sample), 32'd0);

    // Coefficients and sample together: coefficients go first
    @(negedge CLOCK_50);
    a0_in = 18'h02000; a1_in = 18'h00123; a2_in = 18'h3FF00;
    b1_in = 18'h01555; b2_in = 18'h2AAAA;
    coef_valid   = 1'b1;
    sample_in    = 16'h0100;
    sample_valid = 1'b1;
    exp_q.push_back(16'h0100 ^ filt_mask);
    @(negedge CLOCK_50);
    coef_valid   = 1'b0;
    sample_valid = 1'b0;
    drain("coef_drain", 60);
    check("coef_a0_during_req", 32'(nc_a0_seen), 32'h02000);
    check("coef_a1_load", 32'(a1_load), 32'h00123);
    check("coef_b2_load", 32'(b2_load), 32'h2AAAA);
    check("coef_before_sample", 32'(ns_rise_cyc > nc_rise_cyc), 32'd1);
    check("coef_release_gap", 32'(ns_rise_cyc - nc_fall_cyc), 32'd2);

    // Bypass: 8000 passes through, no filter request
    bypass = 1'b1;
    n0     = ns_rise_n;
    send_sample(16'h8000, 16'h8000, 1'b1);
    drain("bypass_drain", 20);
    check("bypass_no_request", 32'(ns_rise_n - n0), 32'd0);
    bypass = 1'b0;

    // Overrun: two more strobes during a 20-cycle compute
    filt_lat = 20;
    v0       = vcount;
    send_sample(16'h1111, 16'h1111 ^ filt_mask, 1'b1);
    wait_new_sample("ovr_request_seen", 10);
    repeat (3) @(negedge CLOCK_50);
    send_sample(16'h2222, 16'h0000, 1'b0);
    repeat (2) @(negedge CLOCK_50);
    send_sample(16'h3333, 16'h3333 ^ filt_mask, 1'b1);
    drain("ovr_drain", 200);
    check("ovr_count", 32'(overrun_cnt), 32'd1);
    check("ovr_pulses", 32'(vcount - v0), 32'd2);

    // Timeout: filter never answers, sample leaves unfiltered
    filt_lat = 0;
    send_sample(16'h4567, 16'h4567, 1'b1);
    drain("to_drain", 100);
    check("to_req_len", 32'(ns_len), 32'd64);
    check("to_count_1", 32'(timeout_cnt), 32'd1);
    for (int i = 1; i < 300; i++) begin
      logic [15:0] v;
      v = 16'(i * 37 + 5);
      send_sample(v, v, 1'b1);
      drain("to_repeat_drain", 100);
      if (i == 254) check("to_count_255", 32'(timeout_cnt), 32'd255);
    end
    check("to_count_sat", 32'(timeout_cnt), 32'd255);
    check("ovr_count_kept", 32'(overrun_cnt), 32'd1);

    // Reset while a sample request is outstanding
    send_sample(16'h7777, 16'h0000, 1'b0);
    wait_new_sample("rst_mid_request_seen", 10);
    repeat (3) @(negedge CLOCK_50);
    Reset = 1'b1;
    @(negedge CLOCK_50);
    check("rstmid_new_sample", 32'(new_sample), 32'd0);
    check("rstmid_a0_load", 32'(a0_load), 32'h04000);
    check("rstmid_overrun", 32'(overrun_cnt), 32'd0);
    check("rstmid_timeout", 32'(timeout_cnt), 32'd0);
    check("rstmid_valid", 32'(sample_out_valid), 32'd0);
    Reset = 1'b0;
    n0 = ns_rise_n;
    v0 = vcount;
    repeat (80) @(negedge CLOCK_50);
    check("rstmid_no_new_request", 32'(ns_rise_n - n0), 32'd0);
    check("rstmid_no_pulse", 32'(vcount - v0), 32'd0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound on run time
  initial begin
    #(3000000);
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
